// File: rtl/shift_arbiter_pkg.sv
// Shared widths, opcode and state encodings, and the single-stage shift helper.
package shift_arbiter_pkg;

  localparam int unsigned N = 16;
  localparam int unsigned C = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } stateT;

  // One mux stage: move v by a fixed nonzero distance sh, direction and fill chosen by op.
  function automatic logic [N-1:0] shiftStage(logic [N-1:0] v, logic [1:0] op, int unsigned sh);
    logic [N-1:0] r;
    unique case (op)
      OP_ROL:  r = (v << sh) | (v >> (N - sh));
      OP_SLL:  r = v << sh;
      OP_ROR:  r = (v >> sh) | (v << (N - sh));
      OP_SRA:  r = N'($signed(v) >>> sh);
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the shared shifter arbiter.
interface shift_arbiter_if;
  import shift_arbiter_pkg::*;

  logic [1:0]   req;
  logic [1:0]   op0;
  logic [1:0]   op1;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [C-1:0] cnt0;
  logic [C-1:0] cnt1;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic [N-1:0] result;
  logic         busy;

  modport master (
    output req, op0, op1, in0, in1, cnt0, cnt1,
    input  gnt, done, result, busy
  );

  modport slave (
    input  req, op0, op1, in0, in1, cnt0, cnt1,
    output gnt, done, result, busy
  );

endinterface

// File: rtl/shift_arbiter_shifter_core.sv
// Combinational rotate/shift: log2(N) stages of N/2 .. 1 positions, one per count bit.
module shifter_core
  import shift_arbiter_pkg::*;
(
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [1:0]   Op,
  output logic [N-1:0] Out
);

  // Walk the count MSB-first; the stage distance halves as the count bits are consumed.
  always_comb begin
    logic [C-1:0] cntBits;
    int unsigned  sh;
    Out     = In;
    cntBits = Cnt;
    sh      = N >> 1;
    for (int s = 0; s < int'(C); s++) begin
      if (cntBits[C-1]) Out = shiftStage(Out, Op, sh);
      cntBits = cntBits << 1;
      sh      = sh >> 1;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one shifter between two requesters, one operation in flight.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  shift_arbiter_if.slave bus
);

  stateT        state;
  logic         owner;
  logic         lastOwner;
  logic [1:0]   opR;
  logic [N-1:0] inR;
  logic [C-1:0] cntR;
  logic [N-1:0] resultR;
  logic [1:0]   gntR;
  logic [1:0]   doneR;
  logic         busyR;
  logic [N-1:0] shOut;
  logic         pick;

  // Winner for this IDLE cycle: a lone requester wins, a tie goes to whoever did not go last.
  assign pick = (bus.req == 2'b11) ? ~lastOwner : bus.req[1];

  shifter_core uCore (
    .In  (inR),
    .Cnt (cntR),
    .Op  (opR),
    .Out (shOut)
  );

  // Sequencer: latch the winner in IDLE, capture the shifter in EXEC, pulse done in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      lastOwner <= 1'b1;
      opR       <= '0;
      inR       <= '0;
      cntR      <= '0;
      resultR   <= '0;
      gntR      <= '0;
      doneR     <= '0;
      busyR     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            owner <= pick;
            opR   <= pick ? bus.op1  : bus.op0;
            inR   <= pick ? bus.in1  : bus.in0;
            cntR  <= pick ? bus.cnt1 : bus.cnt0;
            gntR  <= pick ? 2'b10 : 2'b01;
            busyR <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resultR   <= shOut;
          doneR     <= gntR;
          lastOwner <= owner;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          gntR  <= '0;
          doneR <= '0;
          busyR <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt    = gntR;
  assign bus.done   = doneR;
  assign bus.result = resultR;
  assign bus.busy   = busyR;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized check of shift_arbiter against a bit-level reference model.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  shift_arbiter_if bus();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit lastOwnerM = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: place each operand bit at its destination position by index arithmetic.
  function automatic logic [15:0] refShift(input logic [1:0] op, input logic [15:0] v, input int c);
    int vv;
    int r;
    int b;
    vv = int'(v);
    r  = 0;
    for (int i = 0; i < 16; i++) begin
      case (op)
        OP_ROL: begin
          b = (vv >> i) & 1;
          r = r | (b << ((i + c) % 16));
        end
        OP_SLL: begin
          b = (i >= c) ? ((vv >> (i - c)) & 1) : 0;
          r = r | (b << i);
        end
        OP_ROR: begin
          b = (vv >> ((i + c) % 16)) & 1;
          r = r | (b << i);
        end
        default: begin
          b = (i + c < 16) ? ((vv >> (i + c)) & 1) : ((vv >> 15) & 1);
          r = r | (b << i);
        end
      endcase
    end
    return 16'(r);
  endfunction

  // One full operation from the current request pattern; want >= 0 overrides the model result.
  task automatic runOne(input bit mutate, input int want, input string tag);
    logic [1:0]  r;
    logic [1:0]  oh;
    logic [15:0] exp;
    bit          w;
    r = bus.req;
    if (r == 2'b11) w = ~lastOwnerM;
    else            w = r[1];
    exp = w ? refShift(bus.op1, bus.in1, int'(bus.cnt1)) : refShift(bus.op0, bus.in0, int'(bus.cnt0));
    if (want >= 0) exp = 16'(want);
    oh = w ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    chk({tag, ":exec_gnt"},  32'(bus.gnt),  32'(oh));
    chk({tag, ":exec_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ":exec_done"}, 32'(bus.done), 32'd0);
    if (mutate) begin
      if (w) bus.in1 = 16'hFFFF;
      else   bus.in0 = 16'hFFFF;
      bus.req = bus.req & ~oh;
    end
    @(posedge clk); #1;
    chk({tag, ":resp_done"},   32'(bus.done),   32'(oh));
    chk({tag, ":resp_result"}, 32'(bus.result), 32'(exp));
    chk({tag, ":resp_gnt"},    32'(bus.gnt),    32'(oh));
    chk({tag, ":resp_busy"},   32'(bus.busy),   32'd1);
    bus.req    = bus.req & ~oh;
    lastOwnerM = w;
    @(posedge clk); #1;
    chk({tag, ":idle_done"},   32'(bus.done),   32'd0);
    chk({tag, ":idle_gnt"},    32'(bus.gnt),    32'd0);
    chk({tag, ":idle_busy"},   32'(bus.busy),   32'd0);
    chk({tag, ":idle_result"}, 32'(bus.result), 32'(exp));
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n      = 1'b1;
    lastOwnerM = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op0  = '0;
    bus.op1  = '0;
    bus.in0  = '0;
    bus.in1  = '0;
    bus.cnt0 = '0;
    bus.cnt1 = '0;
    #12;
    chk("reset_gnt",    32'(bus.gnt),    32'd0);
    chk("reset_done",   32'(bus.done),   32'd0);
    chk("reset_busy",   32'(bus.busy),   32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ROL latency
    bus.op0 = OP_ROL; bus.in0 = 16'h1234; bus.cnt0 = 4'd4; bus.req = 2'b01;
    runOne(1'b0, 'h2341, "t1");

    // Requester 1 SLL, then ROR and SRA
    bus.op1 = OP_SLL; bus.in1 = 16'h8001; bus.cnt1 = 4'd1; bus.req = 2'b10;
    runOne(1'b0, 'h0002, "t2_sll");
    bus.op0 = OP_ROR; bus.in0 = 16'h0001; bus.cnt0 = 4'd1; bus.req = 2'b01;
    runOne(1'b0, 'h8000, "t2_ror");
    bus.op1 = OP_SRA; bus.in1 = 16'h8000; bus.cnt1 = 4'd15; bus.req = 2'b10;
    runOne(1'b0, 'hFFFF, "t2_sra");

    // Zero count passes through for every op
    for (int k = 0; k < 4; k++) begin
      bus.op0 = 2'(k); bus.in0 = 16'hA5C3; bus.cnt0 = 4'd0; bus.req = 2'b01;
      runOne(1'b0, 'hA5C3, "t3_cnt0");
    end

    // Constant contention from reset: strict alternation starting with requester 0
    pulseReset();
    bus.op0 = OP_SLL; bus.in0 = 16'h0001; bus.cnt0 = 4'd3;
    bus.op1 = OP_ROL; bus.in1 = 16'h8000; bus.cnt1 = 4'd1;
    bus.req = 2'b11;
    runOne(1'b0, 'h0008, "t4_r0");
    bus.req = 2'b11;
    runOne(1'b0, 'h0001, "t4_r1");
    for (int k = 0; k < 4; k++) begin
      bus.req = 2'b11;
      runOne(1'b0, (k % 2 == 0) ? 'h0008 : 'h0001, "t4_alt");
    end

    // Operand change and req drop after the latch edge
    bus.op0 = OP_ROL; bus.in0 = 16'h1234; bus.cnt0 = 4'd4; bus.req = 2'b01;
    runOne(1'b1, 'h2341, "t5");

    // Reset in EXEC discards the operation
    bus.op1 = OP_ROL; bus.in1 = 16'h00F0; bus.cnt1 = 4'd4; bus.req = 2'b10;
    @(posedge clk); #1;
    chk("t6_exec_gnt", 32'(bus.gnt), 32'd2);
    rst_n   = 1'b0;
    bus.req = 2'b00;
    #1;
    chk("t6_rst_gnt",    32'(bus.gnt),    32'd0);
    chk("t6_rst_done",   32'(bus.done),   32'd0);
    chk("t6_rst_busy",   32'(bus.busy),   32'd0);
    chk("t6_rst_result", 32'(bus.result), 32'd0);
    @(posedge clk); #1;
    chk("t6_rst_nodone", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    lastOwnerM = 1'b1;
    bus.op0 = OP_SRA; bus.in0 = 16'h4000; bus.cnt0 = 4'd2;
    bus.op1 = OP_SLL; bus.in1 = 16'h0003; bus.cnt1 = 4'd2;
    bus.req = 2'b11;
    runOne(1'b0, 'h1000, "t6_tie_r0");

    // Randomized traffic with idle gaps
    for (int k = 0; k < 60; k++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      if (r == 2'b00) begin
        bus.req = 2'b00;
        @(posedge clk); #1;
        chk("rnd_idle_gnt",  32'(bus.gnt),  32'd0);
        chk("rnd_idle_busy", 32'(bus.busy), 32'd0);
      end else begin
        bus.op0  = 2'($urandom_range(0, 3));
        bus.op1  = 2'($urandom_range(0, 3));
        bus.in0  = 16'($urandom);
        bus.in1  = 16'($urandom);
        bus.cnt0 = 4'($urandom_range(0, 15));
        bus.cnt1 = 4'($urandom_range(0, 15));
        bus.req  = r;
        runOne(($urandom_range(0, 3) == 0), -1, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
